// File: rtl/bcd_conv_arbiter.sv
// rtl/bcd_conv_arbiter.sv - one shared multicycle bin2bcd converter arbitrated among NUM_REQ requesters
// Optional macro BCD_ARB_FIXED_PRIORITY_EN: lowest-index-wins arbitration; default is round-robin.

module bin2bcd #(
   parameter int BITS = 9,
   parameter int BCDW = BITS + (BITS - 4) / 3 + 1
) (
   input  logic [BITS-1:0] bin,
   output logic [BCDW-1:0] bcd
);
   localparam int NFULL = BCDW / 4;

   // Double dabble; a partial top digit never reaches 5 because BCDW just fits the largest value.
   always_comb begin
      bcd = '0;
      for (int i = BITS - 1; i >= 0; i--) begin
         for (int d = 0; d < NFULL; d++) begin
            if (bcd[4*d +: 4] >= 4'd5) bcd[4*d +: 4] = bcd[4*d +: 4] + 4'd3;
         end
         bcd = {bcd[BCDW-2:0], bin[i]};
      end
   end
endmodule

module bcd_conv_arbiter #(
   parameter int BITS = 9,
   parameter int NUM_REQ = 4,
   parameter int CONV_CYCLES = 2,
   localparam int BCDW = BITS + (BITS - 4) / 3 + 1,
   localparam int IDW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic [NUM_REQ-1:0]      req,
   input  logic [NUM_REQ*BITS-1:0] bin,
   output logic [NUM_REQ-1:0]      gnt,
   output logic                    busy,
   output logic                    ack,
   output logic [IDW-1:0]          ack_id,
   output logic [BCDW-1:0]         bcd
);
   localparam int CNTW = (CONV_CYCLES > 1) ? $clog2(CONV_CYCLES) : 1;

   typedef enum logic [1:0] {IDLE, CONV, ACK} state_t;

   state_t          state;
   logic [BITS-1:0] op_q;
   logic [IDW-1:0]  id_q;
   logic [CNTW-1:0] cnt;
   logic [IDW-1:0]  win;
   logic [BCDW-1:0] conv;

   bin2bcd #(.BITS(BITS), .BCDW(BCDW)) u_bin2bcd (
      .bin (op_q),
      .bcd (conv)
   );

`ifdef BCD_ARB_FIXED_PRIORITY_EN
   always_comb begin
      win = '0;
      for (int i = NUM_REQ - 1; i >= 0; i--) begin
         if (req[IDW'(i)]) win = IDW'(i);
      end
   end
`else
   logic [IDW-1:0] rr_ptr;
   logic [IDW-1:0] idx;

   // Scan downward so the candidate closest to rr_ptr is assigned last and wins.
   always_comb begin
      win = '0;
      idx = '0;
      for (int k = NUM_REQ - 1; k >= 0; k--) begin
         idx = (int'(rr_ptr) + k >= NUM_REQ) ? IDW'(int'(rr_ptr) + k - NUM_REQ)
                                             : IDW'(int'(rr_ptr) + k);
         if (req[idx]) win = idx;
      end
   end
`endif

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state  <= IDLE;
         gnt    <= '0;
         busy   <= 1'b0;
         ack    <= 1'b0;
         ack_id <= '0;
         bcd    <= '0;
         op_q   <= '0;
         id_q   <= '0;
         cnt    <= '0;
`ifndef BCD_ARB_FIXED_PRIORITY_EN
         rr_ptr <= '0;
`endif
      end else begin
         case (state)
            IDLE: begin
               if (|req) begin
                  op_q  <= bin[int'(win)*BITS +: BITS];
                  gnt   <= NUM_REQ'(1) << win;
                  id_q  <= win;
                  cnt   <= CNTW'(CONV_CYCLES - 1);
                  busy  <= 1'b1;
                  state <= CONV;
               end
            end
            CONV: begin
               if (cnt != '0) begin
                  cnt <= cnt - 1'b1;
               end else begin
                  bcd    <= conv;
                  ack    <= 1'b1;
                  ack_id <= id_q;
                  gnt    <= '0;
`ifndef BCD_ARB_FIXED_PRIORITY_EN
                  rr_ptr <= (id_q == IDW'(NUM_REQ - 1)) ? '0 : id_q + 1'b1;
`endif
                  state  <= ACK;
               end
            end
            ACK: begin
               ack   <= 1'b0;
               busy  <= 1'b0;
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_bcd_conv_arbiter.sv
// tb/tb_bcd_conv_arbiter.sv - randomized self-checking bench for bcd_conv_arbiter with a behavioural model
// Optional macro BCD_ARB_FIXED_PRIORITY_EN switches the model to lowest-index-wins.

module tb_bcd_conv_arbiter;
   localparam int BITS = 9;
   localparam int NUM_REQ = 4;
   localparam int CONV_CYCLES = 2;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [3:0]  req = '0;
   logic [35:0] bin = '0;
   logic [3:0]  gnt;
   logic        busy;
   logic        ack;
   logic [1:0]  ack_id;
   logic [10:0] bcd;

   int errors = 0;
   int checks = 0;
   int model_rr = 0;
   int last_ack_id = 0;

   bcd_conv_arbiter #(.BITS(BITS), .NUM_REQ(NUM_REQ), .CONV_CYCLES(CONV_CYCLES)) dut (
      .clk    (clk),
      .rst_n  (rst_n),
      .req    (req),
      .bin    (bin),
      .gnt    (gnt),
      .busy   (busy),
      .ack    (ack),
      .ack_id (ack_id),
      .bcd    (bcd)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   function automatic logic [10:0] bcd_ref(input int v);
      logic [15:0] r;
      int          x;
      r = '0;
      x = v;
      for (int d = 0; d < 4; d++) begin
         r[4*d +: 4] = 4'(x % 10);
         x = x / 10;
      end
      return r[10:0];
   endfunction

   function automatic int pick(input logic [3:0] r);
`ifdef BCD_ARB_FIXED_PRIORITY_EN
      for (int i = 0; i < NUM_REQ; i++) if (r[i]) return i;
`else
      for (int k = 0; k < NUM_REQ; k++) if (r[(model_rr + k) % NUM_REQ]) return (model_rr + k) % NUM_REQ;
`endif
      return -1;
   endfunction

   function automatic logic [35:0] rand_ops();
      logic [63:0] t;
      t = {$urandom(), $urandom()};
      return t[35:0];
   endfunction

   // One full transaction from the IDLE sampling edge to the cycle after ack.
   task automatic run_round(input string name, input logic [3:0] r, input logic [35:0] b,
                            input bit perturb, input logic [8:0] pv, input bit hold);
      int          w;
      logic [3:0]  oh;
      logic [10:0] exp_bcd;
      w = pick(r);
      oh = 4'b0001 << w;
      exp_bcd = bcd_ref(int'(b[w*BITS +: BITS]));
      req = r;
      bin = b;
      for (int c = 1; c <= CONV_CYCLES; c++) begin
         @(negedge clk);
         checks++; if (gnt !== oh) begin errors++; $display("FAIL %s gnt c%0d: got %b expected %b", name, c, gnt, oh); end
         checks++; if (busy !== 1'b1) begin errors++; $display("FAIL %s busy c%0d: got %b expected 1", name, c, busy); end
         checks++; if (ack !== 1'b0) begin errors++; $display("FAIL %s early ack c%0d: got %b expected 0", name, c, ack); end
         if (perturb && c == 1) begin
            bin = ~b;
            bin[w*BITS +: BITS] = pv;
         end
      end
      @(negedge clk);
      checks++; if (ack !== 1'b1) begin errors++; $display("FAIL %s ack: got %b expected 1", name, ack); end
      checks++; if (ack_id !== 2'(w)) begin errors++; $display("FAIL %s ack_id: got %0d expected %0d", name, ack_id, w); end
      checks++; if (bcd !== exp_bcd) begin errors++; $display("FAIL %s bcd: got %h expected %h", name, bcd, exp_bcd); end
      checks++; if (gnt !== 4'b0000) begin errors++; $display("FAIL %s gnt in ack: got %b expected 0000", name, gnt); end
      last_ack_id = int'(ack_id);
      model_rr = (w + 1) % NUM_REQ;
      if (!hold) req = r & ~oh;
      @(negedge clk);
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL %s busy after ack: got %b expected 0", name, busy); end
      checks++; if (ack !== 1'b0) begin errors++; $display("FAIL %s ack width: got %b expected 0", name, ack); end
      checks++; if (bcd !== exp_bcd) begin errors++; $display("FAIL %s bcd hold: got %h expected %h", name, bcd, exp_bcd); end
   endtask

   task automatic apply_reset();
      rst_n = 1'b0;
      req = '0;
      @(negedge clk);
      rst_n = 1'b1;
      model_rr = 0;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      req = 4'hF;
      bin = '1;
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         checks++; if (gnt !== 4'b0000) begin errors++; $display("FAIL reset gnt: got %b expected 0000", gnt); end
         checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset busy: got %b expected 0", busy); end
         checks++; if (ack !== 1'b0) begin errors++; $display("FAIL reset ack: got %b expected 0", ack); end
         checks++; if (ack_id !== 2'd0) begin errors++; $display("FAIL reset ack_id: got %0d expected 0", ack_id); end
         checks++; if (bcd !== 11'h000) begin errors++; $display("FAIL reset bcd: got %h expected 000", bcd); end
      end
      rst_n = 1'b1;
      req = '0;
      model_rr = 0;
   endtask

   task automatic test_single();
      run_round("single", 4'b0010, {9'd0, 9'd0, 9'd255, 9'd0}, 1'b0, 9'd0, 1'b0);
      checks++; if (bcd !== 11'h255) begin errors++; $display("FAIL single const bcd: got %h expected 255", bcd); end
   endtask

   task automatic test_contention();
      logic [10:0] expv [4];
      logic [3:0]  r;
      expv = '{11'h000, 11'h009, 11'h100, 11'h511};
      r = 4'hF;
      for (int i = 0; i < 4; i++) begin
         run_round("contention", r, {9'd511, 9'd100, 9'd9, 9'd0}, 1'b0, 9'd0, 1'b0);
         checks++; if (last_ack_id != i) begin errors++; $display("FAIL contention order: got %0d expected %0d", last_ack_id, i); end
         checks++; if (bcd !== expv[i]) begin errors++; $display("FAIL contention const bcd: got %h expected %h", bcd, expv[i]); end
         r = req;
      end
      run_round("rearm", 4'b0101, {9'd511, 9'd100, 9'd9, 9'd0}, 1'b0, 9'd0, 1'b0);
      checks++; if (last_ack_id != 0) begin errors++; $display("FAIL rearm first: got %0d expected 0", last_ack_id); end
      run_round("rearm", req, {9'd511, 9'd100, 9'd9, 9'd0}, 1'b0, 9'd0, 1'b0);
      checks++; if (last_ack_id != 2) begin errors++; $display("FAIL rearm second: got %0d expected 2", last_ack_id); end
   endtask

   task automatic test_operand_stability();
      run_round("stability", 4'b0001, {9'd300, 9'd200, 9'd100, 9'd42}, 1'b1, 9'd7, 1'b0);
      checks++; if (bcd !== 11'h042) begin errors++; $display("FAIL stability const bcd: got %h expected 042", bcd); end
   endtask

   task automatic test_mid_reset();
      run_round("mr_pre", 4'b0001, rand_ops(), 1'b0, 9'd0, 1'b0);
      req = 4'hF;
      bin = rand_ops();
      @(negedge clk);
      rst_n = 1'b0;
      req = '0;
      @(negedge clk);
      checks++; if (gnt !== 4'b0000) begin errors++; $display("FAIL mid_reset gnt: got %b expected 0000", gnt); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL mid_reset busy: got %b expected 0", busy); end
      rst_n = 1'b1;
      model_rr = 0;
      for (int c = 0; c < 4; c++) begin
         checks++; if (ack !== 1'b0) begin errors++; $display("FAIL mid_reset ack c%0d: got %b expected 0", c, ack); end
         @(negedge clk);
      end
      run_round("mr_post", 4'hF, rand_ops(), 1'b0, 9'd0, 1'b0);
      checks++; if (last_ack_id != 0) begin errors++; $display("FAIL mid_reset first grant: got %0d expected 0", last_ack_id); end
      req = '0;
      @(negedge clk);
   endtask

   task automatic test_priority();
      int seen3;
      apply_reset();
      seen3 = 0;
      for (int i = 0; i < 12; i++) begin
         run_round("priority", 4'b1001, rand_ops(), 1'b0, 9'd0, 1'b1);
         if (last_ack_id == 3) seen3++;
      end
      req = '0;
      @(negedge clk);
`ifdef BCD_ARB_FIXED_PRIORITY_EN
      checks++; if (seen3 != 0) begin errors++; $display("FAIL fixed starvation: got %0d grants of 3 expected 0", seen3); end
`else
      checks++; if (seen3 != 6) begin errors++; $display("FAIL rr fairness: got %0d grants of 3 expected 6", seen3); end
`endif
   endtask

   task automatic test_random();
      logic [10:0] held;
      for (int i = 0; i < 40; i++) begin
         if ($urandom_range(0, 3) == 0) begin
            held = bcd;
            req = '0;
            bin = rand_ops();
            @(negedge clk);
            checks++; if (busy !== 1'b0 || gnt !== 4'b0000 || ack !== 1'b0) begin
               errors++; $display("FAIL random idle: got busy=%b gnt=%b ack=%b expected 0", busy, gnt, ack);
            end
            checks++; if (bcd !== held) begin errors++; $display("FAIL random idle bcd: got %h expected %h", bcd, held); end
         end
         run_round("random", 4'($urandom_range(1, 15)), rand_ops(), 1'($urandom_range(0, 1)),
                   9'($urandom_range(0, 511)), 1'($urandom_range(0, 1)));
      end
      req = '0;
      @(negedge clk);
   endtask

   initial begin
      test_reset();
      test_single();
      apply_reset();
      test_contention();
      test_operand_stability();
      test_mid_reset();
      test_priority();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
